// File: rtl/arb_pkg.sv
// Shared select encoding for the 3:1 data mux and its round-robin arbiter.
// The mux integrator imports this package too, so both sides agree on sel_t.
package arb_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;

    // Pointer value after reset; source 0 is searched first.
    localparam logic [1:0] LAST_RST = 2'd2;

    function automatic sel_t idx2sel(input logic [1:0] idx);
        sel_t s;
        case (idx)
            2'd1:    s = SEL_D1;
            2'd2:    s = SEL_D2;
            default: s = SEL_D0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters.
// Search starts at last+1 (mod 3); with no request the winner reads as 0.
module rr_pick3 (
    input  logic [1:0] last,
    input  logic [2:0] in_valid,
    output logic [1:0] win,
    output logic       any
);

    assign any = |in_valid;

    always_comb begin
        win = 2'd0;
        case (last)
            2'd0: begin
                if (in_valid[1])      win = 2'd1;
                else if (in_valid[2]) win = 2'd2;
                else                  win = 2'd0;
            end
            2'd1: begin
                if (in_valid[2])      win = 2'd2;
                else if (in_valid[0]) win = 2'd0;
                else if (in_valid[1]) win = 2'd1;
                else                  win = 2'd0;
            end
            default: begin
                if (in_valid[0])      win = 2'd0;
                else if (in_valid[1]) win = 2'd1;
                else if (in_valid[2]) win = 2'd2;
                else                  win = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arb3.sv
// Three-source round-robin arbiter driving the 3:1 mux select and capturing
// the selected word into a one-deep valid/ready output register.
module rr_arb3
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       in_valid,
    output logic [2:0]       in_ready,
    output sel_t             sel,
    input  logic [WIDTH-1:0] mux_y,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  xfer_cnt
);

    logic [1:0]       last_q, last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNTW-1:0]  xfer_cnt_q, xfer_cnt_d;

    logic [1:0] win;
    logic       any;
    logic       can_take;
    logic       grant;

    rr_pick3 u_pick (
        .last     (last_q),
        .in_valid (in_valid),
        .win      (win),
        .any      (any)
    );

    assign can_take = !out_valid_q || out_ready;
    // Sources must never see a handshake in a reset cycle.
    assign grant    = any && can_take && !reset;

    // Select follows the winner even under backpressure so the mux settles early.
    always_comb begin
        sel      = any ? idx2sel(win) : SEL_D0;
        in_ready = 3'b000;
        if (grant) begin
            case (win)
                2'd0:    in_ready = 3'b001;
                2'd1:    in_ready = 3'b010;
                2'd2:    in_ready = 3'b100;
                default: in_ready = 3'b000;
            endcase
        end
    end

    always_comb begin
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (grant) begin
            last_d      = win;
            out_data_d  = mux_y;
            out_valid_d = 1'b1;
            xfer_cnt_d  = xfer_cnt_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= LAST_RST;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_arb3.sv
// Bench for rr_arb3: directed stimulus pushes expected words into a queue,
// a forked monitor pops and compares them at each output handshake.
module tb_rr_arb3;
    import arb_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [2:0]       in_valid;
    logic             out_ready;
    logic [2:0]       in_ready, in_ready4;
    sel_t             sel, sel4;
    logic [WIDTH-1:0] mux_y, mux_y4;
    logic [WIDTH-1:0] out_data, out_data4;
    logic             out_valid, out_valid4;
    logic [15:0]      xfer_cnt;
    logic [3:0]       xfer_cnt4;

    logic [WIDTH-1:0] dval [3];
    logic [WIDTH-1:0] sb_q [$];
    int               n_checks;
    int               n_err;
    logic             seen11;

    initial begin
        dval[0] = 8'h11;
        dval[1] = 8'h22;
        dval[2] = 8'h33;
    end

    // Behavioural 3:1 mux placed beside each arbiter instance.
    assign mux_y  = (sel == SEL_D0) ? dval[0] : (sel == SEL_D1) ? dval[1] :
                    (sel == SEL_D2) ? dval[2] : 8'h00;
    assign mux_y4 = (sel4 == SEL_D0) ? dval[0] : (sel4 == SEL_D1) ? dval[1] :
                    (sel4 == SEL_D2) ? dval[2] : 8'h00;

    rr_arb3 #(.WIDTH(WIDTH), .CNTW(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mux_y     (mux_y),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    rr_arb3 #(.WIDTH(WIDTH), .CNTW(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .sel       (sel4),
        .mux_y     (mux_y4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs mid-cycle, record expected grant.
    task automatic cyc(input logic [2:0] v, input logic ordy, input int exp_w,
                       input logic [1:0] exp_sel);
        logic [2:0] exp_rdy;
        in_valid  = v;
        out_ready = ordy;
        exp_rdy   = (exp_w < 0) ? 3'b000 : 3'(1 << exp_w);
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("sel", 32'(sel), 32'(exp_sel));
        if (exp_w >= 0) sb_q.push_back(dval[exp_w]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 3'b111;
        out_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 3'b000;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("rst_xfer_cnt4", 32'(xfer_cnt4), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 3'b000;
        out_ready = 1'b0;
        n_checks  = 0;
        n_err     = 0;
        seen11    = 1'b0;

        fork
            forever begin
                logic [WIDTH-1:0] exp;
                @(negedge clk);
                if (sel === 2'b11 || sel4 === 2'b11) seen11 = 1'b1;
                if (!reset && out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL sb_empty: out_data=%0h with no expected word", out_data);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(exp));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data", 32'(out_data), 32'd0);
        chk("init_xfer_cnt", 32'(xfer_cnt), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd0);
        chk("init_sel", 32'(sel), 32'd0);

        // Reset priority and fairness: 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) cyc(3'b111, 1'b1, i % 3, 2'(i % 3));
        chk("fair_xfer_cnt", 32'(xfer_cnt), 32'd6);

        // Single requester.
        for (int i = 0; i < 3; i++) cyc(3'b010, 1'b1, 1, 2'b01);
        chk("single_out_data", 32'(out_data), 32'h22);

        // Backpressure: last=1, so source 2 wins once out_ready rises.
        cyc(3'b101, 1'b0, -1, 2'b10);
        cyc(3'b101, 1'b0, -1, 2'b10);
        chk("bp_out_data", 32'(out_data), 32'h22);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        cyc(3'b101, 1'b1, 2, 2'b10);
        chk("bp_refill_valid", 32'(out_valid), 32'd1);
        chk("bp_xfer_cnt", 32'(xfer_cnt), 32'd10);

        // Drain only.
        cyc(3'b000, 1'b1, -1, 2'b00);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_out_data", 32'(out_data), 32'h33);
        chk("drain_xfer_cnt", 32'(xfer_cnt), 32'd10);

        // Mixed patterns; source 2 withdraws before its turn and the pointer stays put.
        cyc(3'b110, 1'b1, 1, 2'b01);
        cyc(3'b101, 1'b1, 2, 2'b10);
        cyc(3'b011, 1'b1, 0, 2'b00);
        cyc(3'b100, 1'b0, -1, 2'b10);
        cyc(3'b001, 1'b1, 0, 2'b00);
        chk("mixed_xfer_cnt", 32'(xfer_cnt), 32'd14);

        // Reset mid-operation at xfer_cnt = 5.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(3'b111, 1'b1, i % 3, 2'(i % 3));
        chk("pre_rst_xfer_cnt", 32'(xfer_cnt), 32'd5);
        do_reset();
        cyc(3'b111, 1'b1, 0, 2'b00);
        chk("post_rst_xfer_cnt", 32'(xfer_cnt), 32'd1);

        // Counter wrap on the narrow instance: 17 grants total.
        for (int i = 0; i < 16; i++) cyc(3'b111, 1'b1, (i + 1) % 3, 2'((i + 1) % 3));
        chk("wrap_xfer_cnt16", 32'(xfer_cnt), 32'd17);
        chk("wrap_xfer_cnt4", 32'(xfer_cnt4), 32'd1);

        cyc(3'b000, 1'b1, -1, 2'b00);
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        chk("sel_never_11", 32'(seen11), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
